// File: rtl/sdft_pkg.sv
// Shared constants and state encodings for the sliding-DFT scheduler.
package sdft_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned FREQ_BINS  = 320;
   localparam int unsigned FREQ_W     = 16;
   localparam int unsigned BIN_ADDR_W = $clog2(FREQ_BINS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RD_A,
      S_RD_B,
      S_GAP,
      S_BUSY
   } state_t;

   // Successor of S_BUSY once the core reports ready again
   typedef enum logic [1:0] {
      PH_IDLE,
      PH_RD_B,
      PH_ACK
   } phase_t;

endpackage

// File: rtl/sdft_scheduler_if.sv
// Bus bundle between the scheduler, the ADC/display side and the sliding-DFT core.
interface sdft_scheduler_if;
   import sdft_pkg::*;

   logic                  adc_valid;
   logic [DATA_W-1:0]     adc_data;
   logic                  disp_req;
   logic [BIN_ADDR_W-1:0] disp_addr;
   logic                  disp_ack;
   logic [FREQ_W-1:0]     disp_data;
   logic                  overrun;
   logic                  overrun_clr;
   logic [DATA_W-1:0]     sdft_sample;
   logic                  sdft_start;
   logic                  sdft_read;
   logic [BIN_ADDR_W-1:0] sdft_bin_addr;
   logic [FREQ_W-1:0]     sdft_bin_out;
   logic                  sdft_ready;

   modport master (
      input  adc_valid, adc_data, disp_req, disp_addr, overrun_clr,
             sdft_bin_out, sdft_ready,
      output disp_ack, disp_data, overrun, sdft_sample, sdft_start,
             sdft_read, sdft_bin_addr
   );

   modport slave (
      output adc_valid, adc_data, disp_req, disp_addr, overrun_clr,
             sdft_bin_out, sdft_ready,
      input  disp_ack, disp_data, overrun, sdft_sample, sdft_start,
             sdft_read, sdft_bin_addr
   );

endinterface

// File: rtl/sdft_sample_buffer.sv
// One-deep ADC sample buffer with sticky overrun flag.
module sdft_sample_buffer
   import sdft_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              adc_valid,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              issue,
   input  logic              overrun_clr,
   output logic [DATA_W-1:0] pending_data,
   output logic              sample_pending,
   output logic              overrun
);

   // Latest sample always wins; an issue in the same cycle has already taken the old value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_data   <= '0;
         sample_pending <= 1'b0;
      end else begin
         if (adc_valid) begin
            pending_data   <= adc_data;
            sample_pending <= 1'b1;
         end else if (issue) begin
            sample_pending <= 1'b0;
         end
      end
   end

   // Overrun sets when an unissued sample is overwritten; set beats clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (adc_valid && sample_pending && !issue) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/sdft_scheduler.sv
// Arbitrates ADC sample starts and display bin reads onto the sliding-DFT core.
module sdft_scheduler
   import sdft_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   sdft_scheduler_if.master bus
);

   state_t                state_q, state_d;
   phase_t                phase_q;
   logic                  last_was_start;
   logic [DATA_W-1:0]     sample_q;
   logic [BIN_ADDR_W-1:0] bin_addr_q;
   logic [FREQ_W-1:0]     disp_data_q;
   logic                  disp_ack_q;
   logic [DATA_W-1:0]     pending_data;
   logic                  sample_pending;
   logic                  idle_ready, grant_start, grant_read, ack_now;

   sdft_sample_buffer u_buf (
      .clk            (clk),
      .reset          (reset),
      .adc_valid      (bus.adc_valid),
      .adc_data       (bus.adc_data),
      .issue          (grant_start),
      .overrun_clr    (bus.overrun_clr),
      .pending_data   (pending_data),
      .sample_pending (sample_pending),
      .overrun        (bus.overrun)
   );

   // Round-robin grant between a pending sample and a display request
   always_comb begin
      idle_ready  = (state_q == S_IDLE) && bus.sdft_ready;
      grant_start = idle_ready && sample_pending && (!bus.disp_req || !last_was_start);
      grant_read  = idle_ready && bus.disp_req && (!sample_pending || last_was_start);
      ack_now     = (state_q == S_BUSY) && bus.sdft_ready && (phase_q == PH_ACK);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: every pulse is followed by one ignored-ready gap cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (grant_start)     state_d = S_START;
            else if (grant_read) state_d = S_RD_A;
         end
         S_START, S_RD_A, S_RD_B: state_d = S_GAP;
         S_GAP:  state_d = S_BUSY;
         S_BUSY: begin
            if (bus.sdft_ready) state_d = (phase_q == PH_RD_B) ? S_RD_B : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Command operands, read phase tracking and display result capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q        <= PH_IDLE;
         last_was_start <= 1'b0;
         sample_q       <= '0;
         bin_addr_q     <= '0;
         disp_data_q    <= '0;
         disp_ack_q     <= 1'b0;
      end else begin
         if (grant_start) begin
            sample_q       <= pending_data;
            last_was_start <= 1'b1;
            phase_q        <= PH_IDLE;
         end
         if (grant_read) begin
            bin_addr_q     <= bus.disp_addr;
            last_was_start <= 1'b0;
            phase_q        <= PH_RD_B;
         end
         // Second read of the pair returns the wanted bin because of the core's one-read lag
         if (state_q == S_RD_B) phase_q <= PH_ACK;
         disp_ack_q <= ack_now;
         if (ack_now) disp_data_q <= bus.sdft_bin_out;
      end
   end

   // Outputs decoded from state and registers
   always_comb begin
      bus.sdft_start    = (state_q == S_START);
      bus.sdft_read     = (state_q == S_RD_A) || (state_q == S_RD_B);
      bus.sdft_sample   = sample_q;
      bus.sdft_bin_addr = bin_addr_q;
      bus.disp_data     = disp_data_q;
      bus.disp_ack      = disp_ack_q;
   end

endmodule
